// File: rtl/wordcount_pkg.sv
// rtl/wordcount_pkg.sv - shared types and helpers for the wordcount read-out path
package wordcount_pkg;

    localparam int KEY_W = 32;
    localparam int CNT_W = 32;

    // One array word: key in the upper half, occurrence count in the lower half.
    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [CNT_W-1:0] count;
    } wc_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        FLUSH,
        DONE
    } drain_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/accum_drain_if.sv
// rtl/accum_drain_if.sv - array read port and output stream of the drain stage
// master: drain side (drives mem_sel/mem_addr and the out_* beat, takes mem_q and out_ready)
// slave : array/sink side (drives mem_q and out_ready)
interface accum_drain_if;
    import wordcount_pkg::*;

    logic             mem_sel;
    logic [31:0]      mem_addr;
    wc_entry_t        mem_q;
    logic [KEY_W-1:0] out_key;
    logic [CNT_W-1:0] out_count;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output mem_sel, mem_addr, out_key, out_count, out_last, out_valid,
        input  mem_q, out_ready
    );

    modport slave (
        input  mem_sel, mem_addr, out_key, out_count, out_last, out_valid,
        output mem_q, out_ready
    );

endinterface

// File: rtl/accum_drain_fifo.sv
// rtl/accum_drain_fifo.sv - small synchronous FIFO of wc_entry_t, no bypass
// Ports: clk, reset_n (async active-low), push/push_data, pop, head (current
// front entry, meaningful only when count != 0), count (occupancy 0..DEPTH).
module accum_drain_fifo
    import wordcount_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  wc_entry_t                  push_data,
    input  logic                       pop,
    output wc_entry_t                  head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wc_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/accum_drain.sv
// rtl/accum_drain.sv - sweeps accum_array after accumulation and streams non-empty entries
// Ports: clk, reset_n (async active-low), start (pulse, honoured only when idle),
// busy/done status, n_emitted (saturating beat count of the current/last sweep),
// bus (master): mem_sel/mem_addr/mem_q array read port, out_* valid/ready stream.
module accum_drain
    import wordcount_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4,
    parameter bit SKIP_ZERO  = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [31:0]  n_emitted,
    accum_drain_if.master bus
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    generate
        if (RD_LATENCY < 1 || FIFO_DEPTH < RD_LATENCY + 1) begin : g_bad_cfg
            $error("accum_drain: need RD_LATENCY >= 1 and FIFO_DEPTH >= RD_LATENCY+1");
        end
    endgenerate

    drain_state_t          state;
    drain_state_t          state_nxt;
    logic [AW-1:0]         addr_q;
    logic [RD_LATENCY-1:0] pipe_v;
    logic [SW-1:0]         inflight;
    logic [FCW-1:0]        fifo_count;
    wc_entry_t             head;
    logic                  issue;
    logic                  last_addr;
    logic                  push;
    logic                  pop;
    logic                  flush_ok;
    logic                  present;
    logic                  start_ok;

    assign start_ok  = (state == IDLE) && start;
    assign last_addr = (addr_q == AW'(DEPTH - 1));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + SW'(pipe_v[i]);
        end
    end

    // Credit check: every outstanding read already owns a FIFO slot.
    assign issue = (state == SWEEP) && ((SW'(fifo_count) + inflight) < SW'(FIFO_DEPTH));

    // A read returning now releases its credit whether or not it is kept.
    assign push = pipe_v[RD_LATENCY-1] && ((bus.mem_q.count != '0) || !SKIP_ZERO);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                                 state_nxt = SWEEP;
            SWEEP:   if (issue && last_addr)                    state_nxt = FLUSH;
            FLUSH:   if (inflight == '0 && fifo_count == '0)    state_nxt = DONE;
            DONE:                                               state_nxt = IDLE;
            default:                                            state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        bus.mem_sel = (state != IDLE);
    end

    // Address counter stops at DEPTH-1; the FSM leaves SWEEP on that issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else if (start_ok) begin
            addr_q <= '0;
        end else if (issue && !last_addr) begin
            addr_q <= addr_q + AW'(1);
        end
    end

    assign bus.mem_addr = 32'(addr_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
            end
            pipe_v[0] <= issue;
        end
    end

    accum_drain_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (bus.mem_q),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // Hold one entry back until we know whether it is the final one. Once
    // presented, the FIFO can only grow (or, in the flush case, stay put), so
    // valid/last/data remain stable until the transfer.
    always_comb begin
        flush_ok      = (state == FLUSH) && (inflight == '0);
        present       = (fifo_count >= FCW'(2)) || (flush_ok && (fifo_count != '0));
        bus.out_valid = present;
        bus.out_last  = flush_ok && (fifo_count == FCW'(1));
        bus.out_key   = present ? head.key   : '0;
        bus.out_count = present ? head.count : '0;
    end

    assign pop = present && bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_emitted <= '0;
        end else if (start_ok) begin
            n_emitted <= '0;
        end else if (pop) begin
            n_emitted <= sat_inc32(n_emitted);
        end
    end

endmodule

// File: tb/tb_accum_drain.sv
// tb/tb_accum_drain.sv - scoreboard bench for accum_drain with a 1-cycle array model
module tb_accum_drain;
    import wordcount_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] n_emitted;

    accum_drain_if bus();

    accum_drain #(
        .DEPTH      (4),
        .RD_LATENCY (1),
        .FIFO_DEPTH (4),
        .SKIP_ZERO  (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .n_emitted (n_emitted),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [4];
    always @(posedge clk) bus.mem_q <= mem[bus.mem_addr[1:0]];

    int          total = 0;
    int          bad = 0;
    logic [64:0] sb [$];
    int          beats = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;
    int          exp_n = 0;
    int          rmode = 0;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sink ready driver: 0 = always ready, 1 = random, 2 = low until first
    // valid then 20 more cycles low, then random.
    initial begin
        int  stall_n;
        bit  seen;
        stall_n = 0;
        seen    = 1'b0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: begin bus.out_ready = 1'b1; seen = 1'b0; stall_n = 0; end
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!seen) begin
                        bus.out_ready = 1'b0;
                        if (bus.out_valid) seen = 1'b1;
                    end else if (stall_n < 20) begin
                        bus.out_ready = 1'b0;
                        stall_n++;
                    end else begin
                        bus.out_ready = 1'($urandom_range(0, 1));
                    end
                end
            endcase
        end
    end

    // Output monitor: scoreboard pop, stall stability, FIFO bound.
    initial begin
        logic        stalled;
        logic [64:0] held;
        logic [64:0] cur;
        logic [64:0] exp;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            cur = {bus.out_last, bus.out_key, bus.out_count};
            if (reset_n) begin
                if (done) done_cnt++;
                if (bus.out_valid) valid_cnt++;
                if (busy) chk("fifo_bound", 65'(dut.fifo_count <= 3'd4), 65'(1));
                if (stalled) begin
                    chk("stall_valid", 65'(bus.out_valid), 65'(1));
                    chk("stall_data", cur, held);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_extra_beat", cur, 65'(0));
                    end else begin
                        exp = sb.pop_front();
                        chk("beat", cur, exp);
                    end
                    beats++;
                end
                stalled = bus.out_valid && !bus.out_ready;
                held    = cur;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic load(input logic [31:0] c0, input logic [31:0] c1,
                        input logic [31:0] c2, input logic [31:0] c3);
        mem[0] = {32'hDEADBEEF, c0};
        mem[1] = {32'hABADCAFE, c1};
        mem[2] = {32'hFEFEFEFE, c2};
        mem[3] = {32'h34343434, c3};
    endtask

    // Expected beats: non-zero entries in address order, last on the final one.
    task automatic expect_sweep();
        logic [63:0] v [$];
        for (int i = 0; i < 4; i++) begin
            if (mem[i][31:0] != 32'd0) v.push_back(mem[i]);
        end
        for (int j = 0; j < v.size(); j++) begin
            sb.push_back({(j == v.size() - 1), v[j]});
        end
        exp_n = v.size();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) hit = 1'b1;
        end
        if (!hit) chk("done_timeout", 65'(0), 65'(1));
    endtask

    task automatic finish_sweep(input int budget);
        int cyc;
        wait_done(budget, cyc);
        repeat (3) @(negedge clk);
        chk("done_once", 65'(done_cnt), 65'(1));
        chk("sb_drained", 65'(sb.size()), 65'(0));
        chk("n_emitted", 65'(n_emitted), 65'(exp_n));
        chk("idle_busy", 65'(busy), 65'(0));
    endtask

    task automatic run_sweep(input int mode, input int budget);
        rmode    = mode;
        done_cnt = 0;
        expect_sweep();
        pulse_start();
        finish_sweep(budget);
    endtask

    initial begin
        int cyc;

        // Reset state
        load(32'd7, 32'd3, 32'd1, 32'd2);
        #3;
        chk("rst_valid", 65'(bus.out_valid), 65'(0));
        chk("rst_busy", 65'(busy), 65'(0));
        chk("rst_done", 65'(done), 65'(0));
        chk("rst_sel", 65'(bus.mem_sel), 65'(0));
        chk("rst_addr", 65'(bus.mem_addr), 65'(0));
        chk("rst_nemit", 65'(n_emitted), 65'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: all four entries, full rate
        run_sweep(0, 100);

        // 2: entry 2 empty is skipped
        load(32'd7, 32'd3, 32'd0, 32'd2);
        run_sweep(0, 100);

        // 3: nothing to emit
        load(32'd0, 32'd0, 32'd0, 32'd0);
        valid_cnt = 0;
        done_cnt  = 0;
        expect_sweep();
        pulse_start();
        wait_done(50, cyc);
        chk("zero_latency_ok", 65'(cyc <= 9), 65'(1));
        repeat (3) @(negedge clk);
        chk("zero_no_valid", 65'(valid_cnt), 65'(0));
        chk("zero_done_once", 65'(done_cnt), 65'(1));
        chk("zero_nemit", 65'(n_emitted), 65'(0));

        // 4: long stall then random backpressure
        load(32'd7, 32'd3, 32'd1, 32'd2);
        run_sweep(2, 400);
        rmode = 1;
        for (int r = 0; r < 3; r++) run_sweep(1, 400);

        // 5: extra starts mid-sweep are ignored; start right after DONE re-runs
        rmode    = 0;
        done_cnt = 0;
        expect_sweep();
        pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(100, cyc);
        @(posedge clk); #1 start = 1'b1;
        expect_sweep();
        @(posedge clk); #1 start = 1'b0;
        chk("dup_start_done_once", 65'(done_cnt), 65'(1));
        chk("dup_start_sb", 65'(sb.size()), 65'(4));
        done_cnt = 0;
        finish_sweep(100);

        // 6: reset mid-sweep, then clean restart from address 0
        done_cnt = 0;
        beats    = 0;
        expect_sweep();
        pulse_start();
        cyc = 0;
        while (beats < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_2_beats", 65'(beats >= 2), 65'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("abort_valid", 65'(bus.out_valid), 65'(0));
        chk("abort_last", 65'(bus.out_last), 65'(0));
        chk("abort_data", 65'({bus.out_key, bus.out_count}), 65'(0));
        chk("abort_busy", 65'({busy, bus.mem_sel, done}), 65'(0));
        chk("abort_addr", 65'(bus.mem_addr), 65'(0));
        chk("abort_nemit", 65'(n_emitted), 65'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("abort_no_done", 65'(done_cnt), 65'(0));
        run_sweep(0, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
